// File: rtl/axi_rd_arb_2to1.sv
// rtl/axi_rd_arb_2to1.sv - 2:1 AXI read arbiter, one burst in flight at a time
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; default build is fixed priority (s0 wins ties).
module axi_rd_arb_2to1 #(
  parameter int P_AXI_IDWIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [P_AXI_IDWIDTH-1:0] s0_arid,
  input  logic [31:0]              s0_araddr,
  input  logic [3:0]               s0_arlen,
  input  logic                     s0_arvalid,
  output logic                     s0_arready,
  output logic [P_AXI_IDWIDTH-1:0] s0_rid,
  output logic [63:0]              s0_rdata,
  output logic [1:0]               s0_rresp,
  output logic                     s0_rlast,
  output logic                     s0_rvalid,
  input  logic                     s0_rready,
  input  logic [P_AXI_IDWIDTH-1:0] s1_arid,
  input  logic [31:0]              s1_araddr,
  input  logic [3:0]               s1_arlen,
  input  logic                     s1_arvalid,
  output logic                     s1_arready,
  output logic [P_AXI_IDWIDTH-1:0] s1_rid,
  output logic [63:0]              s1_rdata,
  output logic [1:0]               s1_rresp,
  output logic                     s1_rlast,
  output logic                     s1_rvalid,
  input  logic                     s1_rready,
  output logic [P_AXI_IDWIDTH-1:0] m_arid,
  output logic [31:0]              m_araddr,
  output logic [3:0]               m_arlen,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  input  logic [P_AXI_IDWIDTH-1:0] m_rid,
  input  logic [63:0]              m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  input  logic                     m_rvalid,
  output logic                     m_rready
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   win;
  logic   addr_ph, data_ph;
`ifdef AXI_RD_ARB_RR_EN
  logic   ptr_q, ptr_d;
`endif

  // Reset gates the phases so every output is forced low while rst is high.
  assign addr_ph = (state_q == ST_ADDR) && !rst;
  assign data_ph = (state_q == ST_DATA) && !rst;

  always_comb begin
`ifdef AXI_RD_ARB_RR_EN
    if (s0_arvalid && s1_arvalid) win = ~ptr_q;
    else                          win = s1_arvalid;
`else
    win = ~s0_arvalid;
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
`ifdef AXI_RD_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (s0_arvalid || s1_arvalid) begin
          state_d = ST_ADDR;
          gnt_d   = win;
`ifdef AXI_RD_ARB_RR_EN
          ptr_d   = win;
`endif
        end
      end
      ST_ADDR: if (m_arvalid && m_arready) state_d = ST_DATA;
      ST_DATA: if (m_rvalid && m_rready && m_rlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
`ifdef AXI_RD_ARB_RR_EN
      ptr_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
`ifdef AXI_RD_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    m_arvalid  = 1'b0;
    m_arid     = '0;
    m_araddr   = '0;
    m_arlen    = '0;
    m_rready   = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s0_rid     = '0;
    s0_rdata   = '0;
    s0_rresp   = '0;
    s0_rlast   = 1'b0;
    s1_rvalid  = 1'b0;
    s1_rid     = '0;
    s1_rdata   = '0;
    s1_rresp   = '0;
    s1_rlast   = 1'b0;
    if (addr_ph) begin
      if (gnt_q) begin
        m_arvalid  = s1_arvalid;
        m_arid     = s1_arid;
        m_araddr   = s1_araddr;
        m_arlen    = s1_arlen;
        s1_arready = m_arready;
      end else begin
        m_arvalid  = s0_arvalid;
        m_arid     = s0_arid;
        m_araddr   = s0_araddr;
        m_arlen    = s0_arlen;
        s0_arready = m_arready;
      end
    end
    if (data_ph) begin
      if (gnt_q) begin
        m_rready  = s1_rready;
        s1_rvalid = m_rvalid;
        s1_rid    = m_rid;
        s1_rdata  = m_rdata;
        s1_rresp  = m_rresp;
        s1_rlast  = m_rlast;
      end else begin
        m_rready  = s0_rready;
        s0_rvalid = m_rvalid;
        s0_rid    = m_rid;
        s0_rdata  = m_rdata;
        s0_rresp  = m_rresp;
        s0_rlast  = m_rlast;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arb_2to1.sv
// tb/tb_axi_rd_arb_2to1.sv - randomized self-checking bench for axi_rd_arb_2to1
// Transaction-level model: pending requests per master, arbitration rule, and a burst-level slave.
module tb_axi_rd_arb_2to1;
  localparam int IDW  = 5;
  localparam int OUTW = 6 + 2*IDW + 128 + 4 + IDW + 32 + 4 + 2;
`ifdef AXI_RD_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    addr;
    logic [3:0]     len;
    int unsigned    rel;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [1:0][IDW-1:0]   i_arid;
  logic [1:0][31:0]      i_araddr;
  logic [1:0][3:0]       i_arlen;
  logic [1:0]            i_arvalid, i_rready;
  logic [1:0]            o_arready, o_rvalid, o_rlast;
  logic [1:0][IDW-1:0]   o_rid;
  logic [1:0][63:0]      o_rdata;
  logic [1:0][1:0]       o_rresp;
  logic [IDW-1:0]        m_arid, m_rid;
  logic [31:0]           m_araddr;
  logic [3:0]            m_arlen;
  logic                  m_arvalid, m_arready, m_rready, m_rlast, m_rvalid;
  logic [63:0]           m_rdata;
  logic [1:0]            m_rresp;
  logic [OUTW-1:0]       all_out;

  assign all_out = {o_arready, o_rvalid, o_rlast, o_rid, o_rdata, o_rresp,
                    m_arid, m_araddr, m_arlen, m_arvalid, m_rready};

  axi_rd_arb_2to1 #(.P_AXI_IDWIDTH(IDW)) dut (
    .clk(clk), .rst(rst),
    .s0_arid(i_arid[0]), .s0_araddr(i_araddr[0]), .s0_arlen(i_arlen[0]),
    .s0_arvalid(i_arvalid[0]), .s0_arready(o_arready[0]),
    .s0_rid(o_rid[0]), .s0_rdata(o_rdata[0]), .s0_rresp(o_rresp[0]),
    .s0_rlast(o_rlast[0]), .s0_rvalid(o_rvalid[0]), .s0_rready(i_rready[0]),
    .s1_arid(i_arid[1]), .s1_araddr(i_araddr[1]), .s1_arlen(i_arlen[1]),
    .s1_arvalid(i_arvalid[1]), .s1_arready(o_arready[1]),
    .s1_rid(o_rid[1]), .s1_rdata(o_rdata[1]), .s1_rresp(o_rresp[1]),
    .s1_rlast(o_rlast[1]), .s1_rvalid(o_rvalid[1]), .s1_rready(i_rready[1]),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int   errors, checks;
  int   cyc;
  req_t mq0[$], mq1[$], sq[$];
  int   win_log[$];
  int   phase, win, last_win, rbeat, sbeat, ar_wait, ar_hs, ar_mode, r_mode;
  bit   r_hold;
  req_t inflight;
  int   beats_rx[2];
  int   exp_beats[2];

  function automatic logic [63:0] beat_data(input logic [31:0] a, input int i);
    logic [3:0] b;
    b = i[3:0];
    return {a, 28'h0, b};
  endfunction

  function automatic int qsize(input int m);
    return (m == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic req_t front(input int m);
    return (m == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic qpop(input int m);
    if (m == 0) void'(mq0.pop_front());
    else        void'(mq1.pop_front());
  endtask

  task automatic push_req(input int m, input int id, input logic [31:0] a, input int len, input int rel);
    req_t r;
    r.id = IDW'(id); r.addr = a; r.len = 4'(len); r.rel = rel;
    if (m == 0) mq0.push_back(r);
    else        mq1.push_back(r);
    exp_beats[m] += len + 1;
  endtask

  task automatic idle_inputs();
    i_arid = '0; i_araddr = '0; i_arlen = '0; i_arvalid = '0; i_rready = '0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic clear_model();
    mq0.delete(); mq1.delete(); sq.delete(); win_log.delete();
    phase = 0; win = 0; last_win = 1; rbeat = 0; sbeat = 0; ar_wait = 0; ar_hs = 0;
    r_hold = 1'b0; beats_rx = '{0, 0}; exp_beats = '{0, 0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
  endtask

  // Called at posedge+1: masters present their released requests, slave streams queued bursts.
  task automatic drive_inputs();
    for (int m = 0; m < 2; m++) begin
      if (qsize(m) > 0 && cyc >= int'(front(m).rel)) begin
        i_arvalid[m] = 1'b1;
        i_arid[m] = front(m).id; i_araddr[m] = front(m).addr; i_arlen[m] = front(m).len;
      end else begin
        i_arvalid[m] = 1'b0;
        i_arid[m] = IDW'($urandom); i_araddr[m] = $urandom; i_arlen[m] = 4'($urandom);
      end
      i_rready[m] = (r_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    case (ar_mode)
      0:       m_arready = 1'($urandom_range(0, 1));
      2:       m_arready = (ar_wait >= 5);
      default: m_arready = 1'b1;
    endcase
    if (!r_hold) begin
      if (sq.size() > 0 && $urandom_range(0, 3) != 0) begin
        m_rvalid = 1'b1; m_rid = sq[0].id; m_rdata = beat_data(sq[0].addr, sbeat);
        m_rresp = 2'(sbeat); m_rlast = (sbeat == int'(sq[0].len));
      end else begin
        m_rvalid = 1'b0; m_rid = '0; m_rdata = {$urandom, $urandom}; m_rresp = '0; m_rlast = 1'b0;
      end
    end
  endtask

  // Called at negedge: compare DUT outputs against the transaction model, then advance it.
  task automatic monitor_cycle();
    int w, nw;
    req_t r;
    logic [1:0] exp2;
    logic [63:0] ed;
    w = win; nw = 1 - win;
    case (phase)
      0: begin
        checks++;
        if (all_out !== '0) begin
          errors++; $display("FAIL idle_outputs: got %h, want 0", all_out);
        end
        if (i_arvalid != 2'b00) begin
          if (i_arvalid == 2'b11) win = RR ? 1 - last_win : 0;
          else                    win = i_arvalid[1] ? 1 : 0;
          last_win = win;
          win_log.push_back(win);
          phase = 1;
        end
      end
      1: begin
        r = front(w);
        checks++;
        if ({m_arvalid, m_arid, m_araddr, m_arlen} !== {1'b1, r.id, r.addr, r.len}) begin
          errors++; $display("FAIL ar_forward: got v=%b id=%h a=%h l=%h, want v=1 id=%h a=%h l=%h",
                             m_arvalid, m_arid, m_araddr, m_arlen, r.id, r.addr, r.len);
        end
        exp2 = 2'b00; exp2[w] = m_arready;
        checks++;
        if (o_arready !== exp2 || o_rvalid !== 2'b00 || m_rready !== 1'b0) begin
          errors++; $display("FAIL addr_handshake: got arready=%b rvalid=%b m_rready=%b, want arready=%b rvalid=00 m_rready=0",
                             o_arready, o_rvalid, m_rready, exp2);
        end
        if (m_arready) begin
          inflight = r;
          qpop(w);
          sq.push_back({m_arid, m_araddr, m_arlen, 32'd0});
          ar_hs++; rbeat = 0; ar_wait = 0; phase = 2;
        end else begin
          ar_wait++;
        end
      end
      default: begin
        exp2 = 2'b00; exp2[w] = m_rvalid;
        checks++;
        if (o_rvalid !== exp2 || {m_rready, m_arvalid, o_arready} !== {i_rready[w], 3'b000}) begin
          errors++; $display("FAIL data_handshake: got rvalid=%b m_rready=%b m_arvalid=%b arready=%b, want rvalid=%b m_rready=%b 0 00",
                             o_rvalid, m_rready, m_arvalid, o_arready, exp2, i_rready[w]);
        end
        checks++;
        if ({o_rid[nw], o_rdata[nw], o_rresp[nw], o_rlast[nw]} !== '0) begin
          errors++; $display("FAIL nongrant_payload: master %0d got rdata=%h rid=%h, want 0", nw, o_rdata[nw], o_rid[nw]);
        end
        if (m_rvalid) begin
          ed = beat_data(inflight.addr, rbeat);
          checks++;
          if ({o_rid[w], o_rdata[w], o_rresp[w], o_rlast[w]} !== {inflight.id, ed, 2'(rbeat), rbeat == int'(inflight.len)}) begin
            errors++; $display("FAIL beat_route: master %0d beat %0d got id=%h d=%h last=%b, want id=%h d=%h last=%b",
                               w, rbeat, o_rid[w], o_rdata[w], o_rlast[w], inflight.id, ed, rbeat == int'(inflight.len));
          end
        end
        if (m_rvalid && m_rready) begin
          beats_rx[w]++; rbeat++; sbeat++; r_hold = 1'b0;
          if (m_rlast) begin
            void'(sq.pop_front()); sbeat = 0; phase = 0;
          end
        end else begin
          r_hold = m_rvalid;
        end
      end
    endcase
  endtask

  task automatic run_engine(input int max_cyc);
    int n;
    n = 0;
    while (qsize(0) != 0 || qsize(1) != 0 || phase != 0 || sq.size() != 0) begin
      if (n >= max_cyc) begin
        checks++; errors++;
        $display("FAIL engine_timeout: still busy after %0d cycles, want completion", n);
        break;
      end
      drive_inputs();
      @(negedge clk);
      monitor_cycle();
      @(posedge clk); #1;
      n++; cyc++;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_arvalid = 2'b11; i_rready = 2'b11; m_arready = 1'b1; m_rvalid = 1'b1; m_rlast = 1'b1;
    m_rdata = 64'hdead_beef_cafe_f00d;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_during: got %h, want 0", all_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_first_cycle: got %h, want 0", all_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    do_reset();
    ar_mode = 1; r_mode = 0;
    push_req(0, 3, 32'h0000_1000, 3, cyc);
    run_engine(200);
    checks++;
    if (win_log.size() != 1 || win_log[0] != 0) begin
      errors++; $display("FAIL single_grant: got %0d grants, want one to s0", win_log.size());
    end
    checks++;
    if (beats_rx[0] != 4 || beats_rx[1] != 0 || ar_hs != 1) begin
      errors++; $display("FAIL single_beats: got s0=%0d s1=%0d ar=%0d, want 4 0 1", beats_rx[0], beats_rx[1], ar_hs);
    end
  endtask

  task automatic test_arb_order();
    int exp_w;
    do_reset();
    ar_mode = 0; r_mode = 1;
    for (int k = 0; k < 4; k++) begin
      push_req(0, k, 32'h0000_2000 + 32'(k * 16), k, cyc);
      push_req(1, 8 + k, 32'h0000_3000 + 32'(k * 16), 3 - k, cyc);
    end
    run_engine(1000);
    for (int k = 0; k < 8; k++) begin
      exp_w = RR ? (k % 2) : (k / 4);
      checks++;
      if (k >= win_log.size() || win_log[k] != exp_w) begin
        errors++; $display("FAIL arb_order[%0d]: got %0d, want %0d", k, (k < win_log.size()) ? win_log[k] : -1, exp_w);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ar_mode = 2; r_mode = 1;
    push_req(0, 5, 32'h0000_4440, 7, cyc);
    run_engine(300);
    checks++;
    if (ar_hs != 1 || beats_rx[0] != 8 || beats_rx[1] != 0) begin
      errors++; $display("FAIL backpressure: got ar=%0d s0=%0d s1=%0d, want 1 8 0", ar_hs, beats_rx[0], beats_rx[1]);
    end
  endtask

  task automatic test_pending();
    do_reset();
    ar_mode = 1; r_mode = 0;
    push_req(0, 1, 32'h0000_5000, 7, cyc);
    push_req(1, 2, 32'h0000_6000, 2, cyc + 6);
    run_engine(300);
    checks++;
    if (win_log.size() != 2 || win_log[0] != 0 || win_log[1] != 1) begin
      errors++; $display("FAIL pending_order: got %0d grants, want s0 then s1", win_log.size());
    end
    checks++;
    if (beats_rx[0] != 8 || beats_rx[1] != 3) begin
      errors++; $display("FAIL pending_beats: got s0=%0d s1=%0d, want 8 3", beats_rx[0], beats_rx[1]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_arvalid[0] = 1'b1; i_arid[0] = 5'h07; i_araddr[0] = 32'h0000_7000; i_arlen[0] = 4'd3;
    m_arready = 1'b1; i_rready = 2'b11;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({m_arvalid, o_arready} !== 3'b101) begin
      errors++; $display("FAIL mid_addr: got arvalid=%b arready=%b, want 1 01", m_arvalid, o_arready);
    end
    @(posedge clk); #1;
    i_arvalid = 2'b00;
    for (int b = 0; b < 2; b++) begin
      m_rvalid = 1'b1; m_rid = 5'h07; m_rdata = beat_data(32'h0000_7000, b); m_rlast = 1'b0;
      @(negedge clk);
      checks++;
      if ({o_rvalid, o_rdata[0]} !== {2'b01, beat_data(32'h0000_7000, b)}) begin
        errors++; $display("FAIL mid_beat%0d: got rvalid=%b d=%h, want 01 %h", b, o_rvalid, o_rdata[0], beat_data(32'h0000_7000, b));
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    m_rdata = beat_data(32'h0000_7000, 2);
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL mid_reset: got %h, want 0", all_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL after_mid_reset: got %h, want 0", all_out);
    end
    @(posedge clk); #1;
    idle_inputs();
    clear_model();
    ar_mode = 0; r_mode = 1;
    push_req(1, 9, 32'h0000_8000, 1, cyc);
    push_req(0, 4, 32'h0000_9000, 2, cyc);
    run_engine(300);
    checks++;
    if (win_log.size() != 2 || win_log[0] != 0 || win_log[1] != 1 || beats_rx[0] != 3 || beats_rx[1] != 2) begin
      errors++; $display("FAIL post_reset_service: got grants=%0d s0=%0d s1=%0d, want s0,s1 3 2", win_log.size(), beats_rx[0], beats_rx[1]);
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      do_reset();
      ar_mode = round; r_mode = round % 2;
      for (int k = 0; k < 6; k++) begin
        push_req(0, $urandom_range(0, 31), $urandom, $urandom_range(0, 15), cyc + $urandom_range(0, 60));
        push_req(1, $urandom_range(0, 31), $urandom, $urandom_range(0, 15), cyc + $urandom_range(0, 60));
      end
      mq0.sort() with (item.rel);
      mq1.sort() with (item.rel);
      run_engine(4000);
      checks++;
      if (beats_rx[0] != exp_beats[0] || beats_rx[1] != exp_beats[1] || ar_hs != 12) begin
        errors++; $display("FAIL random_totals[%0d]: got s0=%0d s1=%0d ar=%0d, want %0d %0d 12",
                           round, beats_rx[0], beats_rx[1], ar_hs, exp_beats[0], exp_beats[1]);
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; ar_mode = 1; r_mode = 0;
    rst = 1'b1;
    idle_inputs();
    clear_model();
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_arb_order();
    test_backpressure();
    test_pending();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arb_2to1.md
AXI_RD_ARB_2TO1 -- requirements
Module: axi_rd_arb_2to1

Interface
REQ-001 Parameter P_AXI_IDWIDTH, default 5: width of all ARID/RID ports.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 s0_/s1_arid  in  P_AXI_IDWIDTH  per-master read ID.
REQ-005 s0_/s1_araddr  in  32  per-master read address.
REQ-006 s0_/s1_arlen  in  4  per-master burst length minus 1.
REQ-007 s0_/s1_arvalid  in  1;  s0_/s1_arready  out  1  per-master AR handshake.
REQ-008 s0_/s1_rid, _rdata, _rresp, _rlast  out  P_AXI_IDWIDTH/64/2/1  per-master R payload.
REQ-009 s0_/s1_rvalid  out  1;  s0_/s1_rready  in  1  per-master R handshake.
REQ-010 m_arid, m_araddr, m_arlen, m_arvalid  out  P_AXI_IDWIDTH/32/4/1;  m_arready  in  1  shared slave AR.
REQ-011 m_rid, m_rdata, m_rresp, m_rlast, m_rvalid  in  P_AXI_IDWIDTH/64/2/1/1;  m_rready  out  1  shared slave R.

Function
REQ-012 FSM states IDLE, ADDR, DATA; one read burst outstanding at a time.
REQ-013 IDLE: if any sN_arvalid, register grant gnt and last-winner ptr, go ADDR next cycle; else stay.
REQ-014 Arbitration (RR mode): both requesting -> grant master not equal to last winner; one requesting -> that one.
REQ-015 ADDR: m_arvalid = s<gnt>_arvalid, m_ar* payload = s<gnt>_ar* (combinational mux); s<gnt>_arready = m_arready.
REQ-016 ADDR -> DATA on m_arvalid & m_arready same cycle.
REQ-017 DATA: s<gnt>_r* = m_r*, s<gnt>_rvalid = m_rvalid, m_rready = s<gnt>_rready.
REQ-018 DATA -> IDLE on m_rvalid & m_rready & m_rlast; new arbitration takes effect in following IDLE cycle.
REQ-019 Non-granted master: arready=0, rvalid=0 in all states; its payload outputs driven 0.
REQ-020 m_arvalid=0 and m_rready=0 in IDLE; m_rready=0 in ADDR.
REQ-021 Request from non-granted master during ADDR/DATA is held pending, never dropped; served at next IDLE.
REQ-022 Minimum AR latency: sN_arvalid asserted in IDLE -> m_arvalid high on next cycle (1 clk).
REQ-023 m_r* beats arriving in IDLE/ADDR are not accepted (m_rready=0); slave assumed compliant.
REQ-024 No beat counting against arlen; burst end determined solely by m_rlast.

Reset
REQ-025 rst high: state=IDLE, gnt=0, last-winner ptr=1 (master 0 wins first tie).
REQ-026 All outputs 0 during and on first cycle after reset (arready, rvalid, m_arvalid, m_rready, payloads).
REQ-027 rst mid-ADDR/DATA aborts burst; no further beats forwarded; shared slave reset on same rst.

Configuration
REQ-028 Macro AXI_RD_ARB_RR_EN defined: round-robin per REQ-014.
REQ-029 Macro undefined: fixed priority, master 0 always wins simultaneous requests; ptr register removed.

Verification
REQ-030 Single request: s0 arvalid, araddr=0x1000, arlen=3 -> m_arvalid next clk, 4 beats on s0 only, s1_rvalid stays 0, FSM back to IDLE after rlast.
REQ-031 Simultaneous requests after reset, RR on: s0 served first, s1 next; repeat -> order alternates s0,s1,s0,s1.
REQ-032 Simultaneous continuous requests, RR off: s0 served every time, s1 starved; s1 alone -> s1 served.
REQ-033 Backpressure: m_arready low 5 clks then high -> payload stable, handshake completes once; s0_rready toggling -> m_rready follows, no beat lost or duplicated.
REQ-034 s1 request arrives mid-s0 burst (arlen=7) -> s1_arready 0 until s0 rlast accepted, s1 AR issued 1 clk after return to IDLE.
REQ-035 rst asserted in DATA after 2 of 4 beats -> all outputs 0 next cycle, state IDLE, new request then served normally.
